// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit order,
// active-high glyphs for hex digits 0-F, and the digit-index width helper.
package ssd_pkg;

    // Bit positions inside the 7-bit segment bus {g,f,e,d,c,b,a}
    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    localparam logic [6:0] SEG_OFF   = 7'h00;
    localparam logic [6:0] SEG_HEX_0 = 7'h3F;
    localparam logic [6:0] SEG_HEX_1 = 7'h06;
    localparam logic [6:0] SEG_HEX_2 = 7'h5B;
    localparam logic [6:0] SEG_HEX_3 = 7'h4F;
    localparam logic [6:0] SEG_HEX_4 = 7'h66;
    localparam logic [6:0] SEG_HEX_5 = 7'h6D;
    localparam logic [6:0] SEG_HEX_6 = 7'h7D;
    localparam logic [6:0] SEG_HEX_7 = 7'h07;
    localparam logic [6:0] SEG_HEX_8 = 7'h7F;
    localparam logic [6:0] SEG_HEX_9 = 7'h6F;
    localparam logic [6:0] SEG_HEX_A = 7'h77;
    localparam logic [6:0] SEG_HEX_B = 7'h7C;
    localparam logic [6:0] SEG_HEX_C = 7'h39;
    localparam logic [6:0] SEG_HEX_D = 7'h5E;
    localparam logic [6:0] SEG_HEX_E = 7'h79;
    localparam logic [6:0] SEG_HEX_F = 7'h71;

    function automatic int unsigned idx_width(input int unsigned digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/ssd_scan_driver_hex7seg.sv
// Combinational hex nibble to active-high seven-segment glyph decoder.
module hex7seg
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver with tear-free frame-boundary commit.
// Optional macro SSD_LZB_EN enables leading-zero blanking.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned PRESCALE   = 50000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic                  frame
);

    localparam int unsigned IW = idx_width(DIGITS);
    localparam int unsigned PW = $clog2(PRESCALE);
    localparam int unsigned VW = 4 * DIGITS;
    localparam int unsigned FW = 5 * DIGITS;

    localparam logic [PW-1:0]     PCNT_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_POL    = {DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]        SEG_POL   = {7{ACTIVE_LOW}};

    if (DIGITS < 2) begin : g_bad_digits
        $error("ssd_scan_driver: DIGITS must be at least 2");
    end
    if (PRESCALE < 2) begin : g_bad_prescale
        $error("ssd_scan_driver: PRESCALE must be at least 2");
    end

    logic [PW-1:0]     pcnt_q, pcnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [FW-1:0]     disp_q, disp_d;
    logic [FW-1:0]     pend_q, pend_d;
    logic              pend_flag_q, pend_flag_d;
    logic              frame_q, frame_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              seg_dp_q, seg_dp_d;

    logic              tc;
    logic              boundary;
    logic [VW-1:0]     disp_val;
    logic [DIGITS-1:0] disp_dp;
    logic [DIGITS-1:0] show;
    logic [DIGITS-1:0] onehot;
    logic [3:0]        cur_nibble;
    logic              cur_dp;
    logic              cur_show;
    logic [6:0]        cur_glyph;
    logic              lit;

    // Display/pending registers hold {dp, value}
    assign disp_val = disp_q[VW-1:0];
    assign disp_dp  = disp_q[FW-1:VW];

    // Scan timing
    always_comb begin
        tc       = (pcnt_q == PCNT_LAST);
        boundary = tc && (idx_q == IDX_LAST);
        pcnt_d   = tc ? '0 : pcnt_q + PW'(1);
        idx_d    = idx_q;
        if (tc) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
    end

    // A load on the boundary cycle stays pending; the commit uses the old pend_q.
    always_comb begin
        pend_d      = pend_q;
        pend_flag_d = pend_flag_q;
        disp_d      = disp_q;
        frame_d     = boundary;
        if (boundary && pend_flag_q) begin
            disp_d      = pend_q;
            pend_flag_d = 1'b0;
        end
        if (load) begin
            pend_d      = {dp, value};
            pend_flag_d = 1'b1;
        end
    end

`ifdef SSD_LZB_EN
    logic lzb_seen;

    // Walk from the top digit down; a digit is shown once any nonzero nibble is at or above it.
    always_comb begin
        show     = '0;
        lzb_seen = 1'b0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            lzb_seen = lzb_seen | (disp_val[i*4 +: 4] != 4'h0);
            show[i]  = lzb_seen | disp_dp[i] | (i == 0);
        end
    end
`else
    assign show = '1;
`endif

    always_comb begin
        onehot     = '0;
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_show   = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IW'(i)) begin
                onehot[i]  = 1'b1;
                cur_nibble = disp_val[i*4 +: 4];
                cur_dp     = disp_dp[i];
                cur_show   = show[i];
            end
        end
    end

    hex7seg u_hex7seg (
        .nibble (cur_nibble),
        .seg    (cur_glyph)
    );

    // Output stage: build active-high, then apply polarity
    always_comb begin
        lit      = ~blank & cur_show;
        an_d     = (lit ? onehot : '0) ^ AN_POL;
        seg_d    = (lit ? cur_glyph : SEG_OFF) ^ SEG_POL;
        seg_dp_d = (lit & cur_dp) ^ ACTIVE_LOW;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q      <= '0;
            idx_q       <= '0;
            disp_q      <= '0;
            pend_q      <= '0;
            pend_flag_q <= 1'b0;
            frame_q     <= 1'b0;
            an_q        <= AN_POL;
            seg_q       <= SEG_POL;
            seg_dp_q    <= ACTIVE_LOW;
        end else begin
            pcnt_q      <= pcnt_d;
            idx_q       <= idx_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_flag_q <= pend_flag_d;
            frame_q     <= frame_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            seg_dp_q    <= seg_dp_d;
        end
    end

    assign an     = an_q;
    assign seg    = seg_q;
    assign seg_dp = seg_dp_q;
    assign frame  = frame_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed self-checking bench for ssd_scan_driver (DIGITS=4, PRESCALE=4, active-low).
module tb_ssd_scan_driver;

    localparam int unsigned DIGITS     = 4;
    localparam int unsigned PRESCALE   = 4;
    localparam bit          ACTIVE_LOW = 1'b1;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        load  = 1'b0;
    logic        blank = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp    = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        seg_dp;
    logic        frame;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ssd_scan_driver #(
        .DIGITS     (DIGITS),
        .PRESCALE   (PRESCALE),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .value  (value),
        .dp     (dp),
        .blank  (blank),
        .an     (an),
        .seg    (seg),
        .seg_dp (seg_dp),
        .frame  (frame)
    );

    // Active-high glyphs 0-F
    logic [6:0] hex_lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference state: edges since reset release, displayed/pending {dp, value}
    int          k;
    logic [19:0] m_disp;
    logic [19:0] m_pend;
    logic        m_pflag;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    function automatic logic shown(input int d);
`ifdef SSD_LZB_EN
        logic hi = 1'b0;
        for (int j = d; j < 4; j++) begin
            if (m_disp[j*4 +: 4] != 4'h0) hi = 1'b1;
        end
        return (d == 0) || m_disp[16+d] || hi;
`else
        return (d >= 0);
`endif
    endfunction

    task automatic model_reset();
        k       = 0;
        m_disp  = '0;
        m_pend  = '0;
        m_pflag = 1'b0;
    endtask

    // One clock: check outputs produced by this edge, then advance the reference.
    task automatic step(input string tag);
        int         d;
        logic       vis;
        logic [3:0] nib;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        @(posedge clk);
        #1;
        k++;
        d       = ((k - 1) / 4) % 4;
        nib     = m_disp[d*4 +: 4];
        vis     = !blank && shown(d);
        exp_an  = vis ? ~(4'b0001 << d) : 4'hF;
        exp_seg = vis ? ~hex_lut[nib] : 7'h7F;
        exp_dp  = vis ? ~m_disp[16+d] : 1'b1;
        check_eq({tag, ".an"}, 32'(an), 32'(exp_an));
        check_eq({tag, ".seg"}, 32'(seg), 32'(exp_seg));
        check_eq({tag, ".dp"}, 32'(seg_dp), 32'(exp_dp));
        check_eq({tag, ".frame"}, 32'(frame), 32'((k % 16) == 0));
        if ((k % 16) == 0 && m_pflag) begin
            m_disp  = m_pend;
            m_pflag = 1'b0;
        end
        if (load) begin
            m_pend  = {dp, value};
            m_pflag = 1'b1;
        end
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        model_reset();
        #12;
        check_eq("rst.an", 32'(an), 32'h0000_000F);
        check_eq("rst.seg", 32'(seg), 32'h0000_007F);
        check_eq("rst.dp", 32'(seg_dp), 32'h1);
        check_eq("rst.frame", 32'(frame), 32'h0);
        rst_n = 1'b1;

        // Free-running scan after release
        run(4, "scan0");
        check_eq("first_digit.an", 32'(an), 32'h0000_000E);
        step("scan1");
        check_eq("second_digit.an", 32'(an), 32'h0000_000D);
        run(31, "scan");

        // Mid-frame load: visible only after the boundary at k=48
        value = 16'h12A8;
        dp    = 4'b0000;
        load  = 1'b1;
        step("load_mid");
        load  = 1'b0;
        run(11, "hold_old");
        check_eq("old_until_boundary.seg", 32'(seg), 32'h0000_0040);
        step("commit0");
        check_eq("d0_is_8.seg", 32'(seg), 32'h0000_0000);
        run(4, "commit1");
        check_eq("d1_is_A.seg", 32'(seg), 32'h0000_0008);
        run(4, "commit2");
        check_eq("d2_is_2.seg", 32'(seg), 32'h0000_0024);
        run(4, "commit3");
        check_eq("d3_is_1.seg", 32'(seg), 32'h0000_0079);
        run(3, "commit_end");

        // Load on the exact boundary edge (k=80)
        run(5, "pre_y");
        value = 16'h0F3C;
        dp    = 4'b0001;
        load  = 1'b1;
        step("load_y");
        load  = 1'b0;
        run(9, "pre_x");
        value = 16'h4567;
        dp    = 4'b0000;
        load  = 1'b1;
        step("load_x_boundary");
        load  = 1'b0;
        step("y_shown");
        check_eq("y_d0_is_C.seg", 32'(seg), 32'h0000_0046);
        check_eq("y_d0_dp.dp", 32'(seg_dp), 32'h0);
        run(15, "y_frame");
        step("x_shown");
        check_eq("x_d0_is_7.seg", 32'(seg), 32'h0000_0078);

        // Blank for 5 cycles; scan phase must continue underneath
        run(2, "pre_blank");
        blank = 1'b1;
        run(5, "blank");
        check_eq("blank.an", 32'(an), 32'h0000_000F);
        check_eq("blank.seg", 32'(seg), 32'h0000_007F);
        blank = 1'b0;
        run(12, "post_blank");

        // Leading-zero blanking scenarios (all digits shown when disabled)
        value = 16'h0005;
        dp    = 4'b0000;
        load  = 1'b1;
        step("load_05");
        load  = 1'b0;
        run(20, "show_05");
`ifdef SSD_LZB_EN
        check_eq("lzb_d2_off.an", 32'(an), 32'h0000_000F);
`else
        check_eq("nolzb_d2_on.an", 32'(an), 32'h0000_000B);
`endif
        run(7, "show_05b");
        dp   = 4'b0100;
        load = 1'b1;
        step("load_05_dp");
        load = 1'b0;
        run(20, "show_05_dp");
`ifdef SSD_LZB_EN
        check_eq("lzb_d1_off.an", 32'(an), 32'h0000_000F);
`else
        check_eq("nolzb_d1_on.an", 32'(an), 32'h0000_000D);
`endif
        run(4, "show_05_dp_d2");
        check_eq("dp_d2.an", 32'(an), 32'h0000_000B);
        check_eq("dp_d2.seg", 32'(seg), 32'h0000_0040);
        check_eq("dp_d2.dp", 32'(seg_dp), 32'h0);
        run(7, "show_05_dp_end");

        // Reset mid-frame with a pending load
        run(3, "pre_rst");
        value = 16'hFFFF;
        dp    = 4'b1111;
        load  = 1'b1;
        step("load_lost");
        load  = 1'b0;
        run(2, "pre_rst2");
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst.an", 32'(an), 32'h0000_000F);
        check_eq("async_rst.seg", 32'(seg), 32'h0000_007F);
        check_eq("async_rst.dp", 32'(seg_dp), 32'h1);
        check_eq("async_rst.frame", 32'(frame), 32'h0);
        #3;
        rst_n = 1'b1;
        model_reset();
        run(20, "after_rst");
        check_eq("no_commit.seg", 32'(seg), 32'h0000_0040);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

Multiplexed seven-segment display driver on the output side of the board I/O path; debounced inputs come in, display data goes out through this block. It holds a DIGITS-wide hex value, scans one digit at a time with a prescaled refresh counter, and drives shared segment lines plus per-digit enables. New values are committed only at frame boundaries, so a digit never shows a mix of old and new data (tear-free update).

## Interface
Parameters:
- DIGITS, 4: number of digits scanned; minimum 2.
- PRESCALE, 50000: clk cycles each digit stays enabled; minimum 2.
- ACTIVE_LOW, 1: 1 = an/seg/seg_dp active-low; 0 = active-high.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- load  in  1  strobe; captures value/dp into pending register.
- value  in  4*DIGITS  hex nibbles; digit 0 = value[3:0] (rightmost).
- dp  in  DIGITS  decimal-point request per digit.
- blank  in  1  level; forces all digits off while high.
- an  out  DIGITS  digit enables, one-hot (polarity per ACTIVE_LOW).
- seg  out  7  segments {g,f,e,d,c,b,a}.
- seg_dp  out  1  decimal point of the enabled digit.
- frame  out  1  one-cycle pulse on each commit boundary.

## Operation
- Prescaler pcnt counts 0..PRESCALE-1, wraps. Terminal count (tc) = pcnt==PRESCALE-1.
- Digit index idx advances on tc, mod DIGITS; DIGITS-1 wraps to 0.
- Boundary = tc && idx==DIGITS-1. At boundary: if pend_flag, disp_reg <= pend_reg, pend_flag <= 0; frame <= 1 (pulses every boundary, committed or not).
- load: pend_reg <= {dp, value}, pend_flag <= 1. load on a boundary cycle: the commit uses the pre-load pend_reg; the new data stays pending for the next boundary; pend_flag remains 1 (set wins).
- Multiple loads within one frame: last one wins.
- Output stage (registered): nibble = disp_reg digit idx → hex7seg → seg; seg_dp = disp dp[idx]; an = one-hot(idx). blank=1 → an all inactive, seg/seg_dp inactive; scan counters keep running.
- Encoding (active-high): 0→0x3F, 1→0x06, 8→0x7F, A→0x77, F→0x71. Active-low outputs are the bitwise inverse.

## Timing
- Reset values: pcnt=0, idx=0, disp_reg=0, pend_reg=0, pend_flag=0, frame=0, an/seg/seg_dp all inactive.
- First clock after rst_n release: an enables digit 0 showing "0".
- Output latency: 1 cycle from idx/disp_reg/blank change to an/seg.
- Commit latency: load → visible no later than DIGITS*PRESCALE+1 cycles; new data first shows on digit 0.
- frame asserted the cycle after the boundary, for exactly 1 cycle.
- Reset mid-frame: all state returns to reset values asynchronously; pending data lost.

## Configuration
- SSD_LZB_EN defined: leading-zero blanking; digits above the most significant nonzero nibble of disp_reg are off (an inactive); digit 0 is always shown; a digit with its dp bit set is never blanked.
- Not defined: all DIGITS digits always shown (subject to blank).

## Structure
- Package ssd_pkg: 7-bit segment constants for 0–F, segment bit-order constants, idx width via $clog2(DIGITS).
- Sub-module hex7seg: combinational nibble → 7-bit active-high pattern; polarity applied in ssd_scan_driver.

## Test plan
(PRESCALE=4, DIGITS=4, ACTIVE_LOW=1 unless stated.)
- Reset release → an=4'b1110, seg=0x40 for 4 cycles, then an=4'b1101; full cycle 1110→1101→1011→0111 repeats every 16 cycles; frame pulses every 16.
- load value=16'h12A8 mid-frame → unchanged until boundary; afterwards digits 0..3 show seg 0x00, 0x08, 0x24, 0x79 (8, A, 2, 1).
- load on the exact boundary cycle → previous pending value committed at that boundary, new value at the following one.
- blank held 5 cycles → an=4'b1111, seg=0x7F, seg_dp=1; scan phase after release matches an unblanked reference run.
- SSD_LZB_EN, value=16'h0005, dp=0 → only digit 0 ever enabled; dp=4'b0100 → digits 0 and 2 enabled, digit 2 shows "0" with seg_dp=0.
- rst_n asserted mid-frame with pending load → outputs inactive immediately; after release digit 0 shows "0", frame arrives 16 cycles later, no commit.
